// File: rtl/ap_mult_pkg.sv
// Shared widths and types for the shared-multiplier scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ap_mult_pkg;
    localparam int NREQ_DEF = 4;   // default number of requesters
    localparam int OPW      = 8;   // operand width
    localparam int RESW     = 16;  // product width

    typedef logic [OPW-1:0]  opnd_t;
    typedef logic [RESW-1:0] prod_t;
endpackage

// File: rtl/ap_mult_8b_r4.sv
// Approximate signed 8x8 multiplier: radix-4 Booth recoding, 3:2 carry-save tree.
// Latency: combinational.
// Backpressure: none (pure function of a, b).
// Ports: a, b = signed operands; p = approximate signed 16-bit product.
module ap_mult_8b_r4
    import ap_mult_pkg::*;
(
    input  opnd_t a,
    input  opnd_t b,
    output prod_t p
);
    // The low four product columns of every partial product are dropped
    // before the tree; the error stays confined to the least-significant bits.
    localparam prod_t TRUNC_MASK = 16'hFFF0;

    prod_t            a_ext;
    logic [OPW:0]     b_ext;
    prod_t            booth_mag [4];
    prod_t            pp        [4];
    prod_t            csa1_s;
    prod_t            csa1_c;
    prod_t            csa2_s;
    prod_t            csa2_c;

    always_comb begin
        a_ext = {{(RESW-OPW){a[OPW-1]}}, a};
        b_ext = {b, 1'b0};
        for (int j = 0; j < 4; j++) begin
            // Booth digit from {b[2j+1], b[2j], b[2j-1]}
            case (b_ext[2*j +: 3])
                3'b001, 3'b010: booth_mag[j] = a_ext;
                3'b011:         booth_mag[j] = a_ext << 1;
                3'b100:         booth_mag[j] = -(a_ext << 1);
                3'b101, 3'b110: booth_mag[j] = -a_ext;
                default:        booth_mag[j] = '0;
            endcase
            pp[j] = (booth_mag[j] << (2*j)) & TRUNC_MASK;
        end

        // Two carry-save layers reduce four rows to two, then one adder.
        csa1_s = pp[0] ^ pp[1] ^ pp[2];
        csa1_c = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
        csa2_s = csa1_s ^ csa1_c ^ pp[3];
        csa2_c = ((csa1_s & csa1_c) | (csa1_s & pp[3]) | (csa1_c & pp[3])) << 1;
    end

    assign p = csa2_s + csa2_c;
endmodule

// File: rtl/ap_mult_sched.sv
// Round-robin scheduler sharing one 8x8 multiplier (exact or approximate) among NREQ requesters.
// Latency: 2 cycles grant-to-result; one grant per cycle sustained when res_ready=1.
// Backpressure: res_ready=0 stalls S2, then S1; req_ready drops to zero once both stages are full.
// Ports: req_valid/req_a/req_b/req_approx/req_ready = per-requester operand channel;
//        res_valid/res_id/res_p/res_ready = result channel; clk, rst = sync active-high reset.
module ap_mult_sched
    import ap_mult_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [OPW*NREQ-1:0]   req_a,
    input  logic [OPW*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]       req_approx,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [RESW-1:0]       res_p,
    input  logic                  res_ready
);
    logic           s1_vld_q,  s1_vld_d;
    opnd_t          s1_a_q,    s1_a_d;
    opnd_t          s1_b_q,    s1_b_d;
    logic [IDW-1:0] s1_id_q,   s1_id_d;
    logic           s1_apx_q,  s1_apx_d;
    logic           s2_vld_q,  s2_vld_d;
    prod_t          s2_p_q,    s2_p_d;
    logic [IDW-1:0] s2_id_q,   s2_id_d;
    logic [IDW-1:0] ptr_q,     ptr_d;

    logic           s2_adv;
    logic           s1_load;
    logic           found;
    logic           grant;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] win_idx;
    logic [NREQ-1:0] grant_oh;
    prod_t          apx_p;
    prod_t          exact_p;
    prod_t          prod;

    ap_mult_8b_r4 u_apx (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (apx_p)
    );

    // Low 16 bits of the sign-extended product equal the signed 8x8 product.
    assign exact_p = {{(RESW-OPW){s1_a_q[OPW-1]}}, s1_a_q} *
                     {{(RESW-OPW){s1_b_q[OPW-1]}}, s1_b_q};
    assign prod    = s1_apx_q ? apx_p : exact_p;

    always_comb begin
        // Round-robin scan starting at ptr; IDW-bit index wraps mod NREQ.
        found    = 1'b0;
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ptr_q + IDW'(k);
            if (!found && req_valid[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end

        s2_adv  = !s2_vld_q || res_ready;
        s1_load = !s1_vld_q || s2_adv;
        grant   = found && s1_load && !rst;

        grant_oh = '0;
        if (grant) begin
            grant_oh[win_idx] = 1'b1;
        end

        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_id_d  = s1_id_q;
        s1_apx_d = s1_apx_q;
        s2_vld_d = s2_vld_q;
        s2_p_d   = s2_p_q;
        s2_id_d  = s2_id_q;
        ptr_d    = ptr_q;

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            // Hold the old result registers when nothing moves in.
            if (s1_vld_q) begin
                s2_p_d  = prod;
                s2_id_d = s1_id_q;
            end
        end

        if (s1_load) begin
            s1_vld_d = grant;
            if (grant) begin
                s1_a_d   = req_a[OPW*win_idx +: OPW];
                s1_b_d   = req_b[OPW*win_idx +: OPW];
                s1_id_d  = win_idx;
                s1_apx_d = req_approx[win_idx];
                ptr_d    = win_idx + IDW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            ptr_q    <= '0;
            s2_id_q  <= '0;
            s2_p_q   <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            ptr_q    <= ptr_d;
            s2_id_q  <= s2_id_d;
            s2_p_q   <= s2_p_d;
        end
        // Operand registers carry no state meaning once s1_vld_q is clear.
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_id_q  <= s1_id_d;
        s1_apx_q <= s1_apx_d;
    end

    assign req_ready = grant_oh;
    assign res_valid = s2_vld_q && !rst;
    assign res_id    = s2_id_q;
    assign res_p     = s2_p_q;
endmodule

// File: tb/tb_ap_mult_sched.sv
// Bench for ap_mult_sched: directed steps plus a grant-driven scoreboard.
// Latency: n/a.
// Backpressure: res_ready driven by the steps (held, pulsed, randomised).
module tb_ap_mult_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    p;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_approx;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [15:0]       res_p;
    logic              res_ready;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    ap_mult_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_approx (req_approx),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_p      (res_p),
        .res_ready  (res_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference product: Booth digits evaluated in integer arithmetic; for the
    // approximate mode each weighted partial product loses its low four bits.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic apx);
        int ai, bi, d, term, acc;
        logic [8:0] bx;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (!apx) begin
            acc = ai * bi;
            return acc[15:0];
        end
        bx  = {b, 1'b0};
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            d    = -2 * int'(bx[2*j+2]) + int'(bx[2*j+1]) + int'(bx[2*j]);
            term = (ai * d) * (4 ** j);
            term = term & -16;
            acc  = acc + term;
        end
        return acc[15:0];
    endfunction

    // Scoreboard: pop on result handshake, push on grant handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_result obs=id%0d exp=none", res_id);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_res_id", 32'(res_id), 32'(e.id));
                    chk("sb_res_p", 32'(res_p), 32'(e.p));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = IDW'(i);
                    e.p  = model(req_a[8*i +: 8], req_b[8*i +: 8], req_approx[i]);
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 50; n++) begin
            if (sb_q.size() == 0 && !res_valid) break;
            cyc();
        end
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] rr_exp [5];
        logic [15:0]     hold_p;
        int              ngrant;
        int              iter;

        rst        = 1'b1;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        req_approx = '0;
        res_ready  = 1'b1;

        // Reset: nothing granted or presented while rst is high.
        cyc();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        cyc();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("post_rst_res_valid", 32'(res_valid), 32'd0);
        chk("post_rst_res_id", 32'(res_id), 32'd0);
        chk("post_rst_res_p", 32'(res_p), 32'd0);

        // Exact mode, -3 * 5 from requester 0, 2-cycle latency.
        req_a[7:0] = 8'hFD;
        req_b[7:0] = 8'h05;
        req_valid  = 4'b0001;
        #1;
        chk("exact_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        #1;
        chk("exact_lat1_valid", 32'(res_valid), 32'd0);
        cyc();
        chk("exact_valid", 32'(res_valid), 32'd1);
        chk("exact_p", 32'(res_p), 32'hFFF1);
        chk("exact_id", 32'(res_id), 32'd0);
        cyc();
        chk("exact_done", 32'(res_valid), 32'd0);

        // Corner product -128 * -128 from requester 2.
        req_a[23:16] = 8'h80;
        req_b[23:16] = 8'h80;
        req_valid    = 4'b0100;
        #1;
        chk("corner_ready", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = '0;
        cyc();
        chk("corner_p", 32'(res_p), 32'h4000);
        chk("corner_id", 32'(res_id), 32'd2);
        drain("corner_drain");

        // Move the pointer back to 0 with a single grant to requester 3.
        req_valid = 4'b1000;
        cyc();
        req_valid = '0;
        drain("ptr_drain");

        // Round robin with all requesters held.
        req_a      = 32'h7F_11_C3_25;
        req_b      = 32'h81_E9_07_9A;
        req_approx = 4'b0101;
        req_valid  = '1;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(rr_exp[k]));
            cyc();
        end
        req_valid = '0;
        drain("rr_drain");

        // Backpressure: 4 stalled cycles, exactly two grants (pointer at 1).
        res_ready = 1'b0;
        req_valid = '1;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        cyc();
        chk("bp_grant2", 32'(req_ready), 32'b0100);
        cyc();
        hold_p = model(req_a[15:8], req_b[15:8], req_approx[1]);
        for (int k = 0; k < 2; k++) begin
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(res_valid), 32'd1);
            chk("bp_hold_id", 32'(res_id), 32'd1);
            chk("bp_hold_p", 32'(res_p), 32'(hold_p));
            cyc();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b1000);
        chk("bp_release_valid", 32'(res_valid), 32'd1);
        cyc();
        req_valid = '0;
        drain("bp_drain");

        // Approximate mode: 1000 random grants under random backpressure.
        req_approx = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
        end
        req_valid = '1;
        ngrant    = 0;
        iter      = 0;
        while (ngrant < 1000 && iter < 5000) begin
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = req_valid & req_ready;
            cyc();
            iter++;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    ngrant++;
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = 8'($urandom);
                end
            end
        end
        chk("apx_grant_count", 32'(ngrant), 32'd1000);
        req_valid = '0;
        res_ready = 1'b1;
        drain("apx_drain");

        // Reset with both stages full.
        req_approx = '0;
        res_ready  = 1'b0;
        req_valid  = '1;
        cyc();
        cyc();
        chk("mid_s2_full", 32'(res_valid), 32'd1);
        chk("mid_s1_full", 32'(req_ready), 32'd0);
        rst       = 1'b1;
        req_valid = 4'b1010;
        sb_q.delete();
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        cyc();
        rst       = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("mid_post_valid", 32'(res_valid), 32'd0);
        chk("mid_post_id", 32'(res_id), 32'd0);
        chk("mid_post_p", 32'(res_p), 32'd0);
        chk("mid_first_grant", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        cyc();
        chk("mid_first_result", 32'(res_valid), 32'd1);
        chk("mid_first_id", 32'(res_id), 32'd1);
        drain("mid_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
